sram_ctrl: RTL
==============

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, request address width.
REQ-002 Parameter ROW_W, default 5, row-address field width; COL_W = ADDR_W-ROW_W (row = upper bits).
REQ-003 Parameter DATA_W, default 8, data word width.
REQ-004 Parameter PRE_CYC, default 2, precharge phase length in cycles (legal >=1).
REQ-005 Parameter WL_CYC, default 2, wordline phase length in cycles (legal >=1).
REQ-006 clk  in  1  single clock, all state updates on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 req_valid in 1 request present; req_ready out 1 controller can accept.
REQ-009 req_we in 1 (1=write); req_addr in ADDR_W; req_wdata in DATA_W.
REQ-010 rsp_valid  out  1  one-cycle completion pulse, reads and writes.
REQ-011 rsp_rdata  out  DATA_W  last read data.
REQ-012 pre_en  out  1  bitline precharge enable, active-high.
REQ-013 wl_en out 1 wordline enable; row_addr out ROW_W; col_addr out COL_W.
REQ-014 we_en out 1 write-driver enable; wdata_out out DATA_W to bitline drivers.
REQ-015 sae  out  1  sense-amp enable; sense_data  in  DATA_W  sense-amp outputs.

Function
REQ-016 FSM states IDLE, PRE, WL, RECOV; req_ready=1 only in IDLE.
REQ-017 IDLE: on req_valid&&req_ready capture req_we, req_addr, req_wdata; next state PRE.
REQ-018 PRE: pre_en=1 for exactly PRE_CYC cycles, then WL.
REQ-019 WL: wl_en=1 for exactly WL_CYC cycles; we_en=1 throughout WL for writes only.
REQ-020 Reads: sae=1 on last WL cycle only; sense_data registered into rsp_rdata at that cycle's closing edge.
REQ-021 RECOV: one cycle, all enables low, rsp_valid=1; then IDLE.
REQ-022 Latency: handshake edge to rsp_valid = PRE_CYC+WL_CYC+1 cycles; next req_ready one cycle after rsp_valid.
REQ-023 pre_en and wl_en never high in the same cycle; sae and we_en never high together.
REQ-024 All control outputs driven from registers, glitch-free.
REQ-025 row_addr, col_addr, wdata_out hold captured values from PRE through next capture.
REQ-026 rsp_rdata unchanged by writes; holds until next read completes.
REQ-027 req_valid while busy: ignored, no capture, requester must hold.
REQ-028 Phase counter width clog2(max(PRE_CYC,WL_CYC)+1), no wrap beyond loaded value.

Reset
REQ-029 rst_n low forces IDLE asynchronously; all outputs 0 except req_ready, which is 1 after reset release.
REQ-030 Reset mid-operation aborts the access: wl_en, we_en, sae, pre_en drop immediately; no rsp_valid generated.
REQ-031 After rst_n deasserts, first request accepted on the first rising edge.

Structure
REQ-032 Package sram_ctrl_pkg holds state encoding and default PRE_CYC/WL_CYC constants.
REQ-033 One sub-module sram_phase_timer: loadable down-counter with done flag, reused for PRE and WL.
REQ-034 Controller drives the existing wordline/bitline driver cells; it contains no driver logic.

Verification (PRE_CYC=2, WL_CYC=2, ADDR_W=8, ROW_W=5)
REQ-035 Write addr 0xA5 data 0x3C at cycle 0 -> pre_en cycles 1-2, wl_en+we_en cycles 3-4, row_addr=0x14, col_addr=0x5, rsp_valid cycle 5.
REQ-036 Read addr 0xA5, sense_data=0x3C -> sae only cycle 4, rsp_rdata=0x3C with rsp_valid cycle 5, req_ready cycle 6.
REQ-037 Back-to-back req_valid held high -> second accept cycle 6, no overlap of pre_en/wl_en on any cycle.
REQ-038 Write after read: rsp_rdata retains the read value.
REQ-039 rst_n low in cycle 3 of a write -> wl_en/we_en 0 at once, no rsp_valid, req_ready 1 after release.
REQ-040 req_valid during PRE with new addr -> ignored; row_addr/col_addr unchanged.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the SRAM array controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRE   = 2'd1,
    S_WL    = 2'd2,
    S_RECOV = 2'd3
  } state_t;

  localparam int DEF_PRE_CYC = 2;
  localparam int DEF_WL_CYC  = 2;

  function automatic int maxi(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable down-counter; done marks the final cycle of a phase.
module sram_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] cnt,
  output logic         done
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= ld_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/sram_ctrl.sv
// Sequences precharge, wordline and sense/write phases for one access.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int ROW_W   = 5,
  parameter int DATA_W  = 8,
  parameter int PRE_CYC = DEF_PRE_CYC,
  parameter int WL_CYC  = DEF_WL_CYC
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      pre_en,
  output logic                      wl_en,
  output logic [ROW_W-1:0]          row_addr,
  output logic [ADDR_W-ROW_W-1:0]   col_addr,
  output logic                      we_en,
  output logic [DATA_W-1:0]         wdata_out,
  output logic                      sae,
  input  logic [DATA_W-1:0]         sense_data
);

  localparam int COL_W = ADDR_W - ROW_W;
  localparam int TW    = $clog2(maxi(PRE_CYC, WL_CYC) + 1);

  state_t        state;
  logic          we_q;
  logic          accept;
  logic          t_load;
  logic [TW-1:0] t_val;
  logic [TW-1:0] t_cnt;
  logic          t_done;

  assign accept = (state == S_IDLE) && req_valid && req_ready;
  assign t_load = accept || ((state == S_PRE) && t_done);
  assign t_val  = (state == S_IDLE) ? TW'(PRE_CYC) : TW'(WL_CYC);

  sram_phase_timer #(
    .W (TW)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (t_load),
    .ld_val (t_val),
    .cnt    (t_cnt),
    .done   (t_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      we_q      <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      pre_en    <= 1'b0;
      wl_en     <= 1'b0;
      we_en     <= 1'b0;
      sae       <= 1'b0;
      row_addr  <= '0;
      col_addr  <= '0;
      wdata_out <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_PRE;
            we_q      <= req_we;
            row_addr  <= req_addr[ADDR_W-1 -: ROW_W];
            col_addr  <= req_addr[COL_W-1:0];
            wdata_out <= req_wdata;
            req_ready <= 1'b0;
            pre_en    <= 1'b1;
          end
        end
        S_PRE: begin
          if (t_done) begin
            state  <= S_WL;
            pre_en <= 1'b0;
            wl_en  <= 1'b1;
            we_en  <= we_q;
            sae    <= !we_q && (WL_CYC == 1);
          end
        end
        S_WL: begin
          if (t_done) begin
            state     <= S_RECOV;
            wl_en     <= 1'b0;
            we_en     <= 1'b0;
            sae       <= 1'b0;
            rsp_valid <= 1'b1;
            if (!we_q) rsp_rdata <= sense_data;
          end else begin
            // raise sae so it lands exactly on the last wordline cycle
            sae <= !we_q && (32'(t_cnt) == 2);
          end
        end
        S_RECOV: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
